// File: rtl/mc_bus_pkg.sv
// Shared types and constants for the MCU parallel bus bridge.
// Holds the bridge state encoding, default widths and the strobe active level.
package mc_bus_pkg;

    localparam int unsigned MC_DATA_WIDTH_DEF = 16;
    localparam int unsigned MC_ADD_WIDTH_DEF  = 6;
    localparam int unsigned FILTER_CYCLES_DEF = 2;
    localparam int unsigned FILTER_CNT_W      = 4;

    localparam logic STROBE_ACTIVE   = 1'b0;
    localparam logic STROBE_INACTIVE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ      = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } state_e;

    // Read access sub-phases: strobe issued, register data landing, data held on pad.
    typedef enum logic [1:0] {
        RD_ISSUE   = 2'd0,
        RD_CAPTURE = 2'd1,
        RD_HOLD    = 2'd2
    } rd_phase_e;

    function automatic logic is_active(input logic strobe);
        return strobe == STROBE_ACTIVE;
    endfunction

endpackage

// File: rtl/mc_strobe_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one asynchronous strobe.
// The filtered output only follows the synchronised input after FILTER_CYCLES agreeing samples.
module mc_strobe_filter
    import mc_bus_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF,
    parameter logic        RESET_VAL     = STROBE_INACTIVE
) (
    input  logic clock,
    input  logic reset,
    input  logic strobe_i,
    output logic strobe_o
);

    logic                    sync1_q;
    logic                    sync2_q;
    logic                    filt_q;
    logic                    filt_d;
    logic [FILTER_CNT_W-1:0] cnt_q;
    logic [FILTER_CNT_W-1:0] cnt_d;

    // Count consecutive disagreeing samples; any agreement restarts the run.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == FILTER_CNT_W'(FILTER_CYCLES - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + FILTER_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            filt_q  <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= strobe_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign strobe_o = filt_q;

endmodule

// File: rtl/mc_bus_bridge.sv
// Bridge from the MCU asynchronous parallel bus to single-cycle register strobes.
// Writes commit on the write-enable rising edge; reads issue one strobe and drive registered data.
module mc_bus_bridge
    import mc_bus_pkg::*;
#(
    parameter int unsigned MC_DATA_WIDTH = MC_DATA_WIDTH_DEF,
    parameter int unsigned MC_ADD_WIDTH  = MC_ADD_WIDTH_DEF,
    parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mc_ce,
    input  logic                     mc_we,
    input  logic                     mc_oe,
    input  logic [MC_ADD_WIDTH-1:0]  mc_add,
    input  logic [MC_DATA_WIDTH-1:0] mc_data_i,
    output logic [MC_DATA_WIDTH-1:0] mc_data_o,
    output logic                     mc_data_oe,
    output logic [MC_ADD_WIDTH-1:0]  reg_addr,
    output logic [MC_DATA_WIDTH-1:0] reg_wdata,
    output logic                     reg_wr,
    output logic                     reg_rd,
    input  logic [MC_DATA_WIDTH-1:0] reg_rdata,
    output logic                     bus_err
);

    logic fce;
    logic fwe;
    logic foe;

    mc_strobe_filter #(.FILTER_CYCLES(FILTER_CYCLES), .RESET_VAL(STROBE_INACTIVE)) u_ce_filt (
        .clock    (clock),
        .reset    (reset),
        .strobe_i (mc_ce),
        .strobe_o (fce)
    );

    mc_strobe_filter #(.FILTER_CYCLES(FILTER_CYCLES), .RESET_VAL(STROBE_INACTIVE)) u_we_filt (
        .clock    (clock),
        .reset    (reset),
        .strobe_i (mc_we),
        .strobe_o (fwe)
    );

    mc_strobe_filter #(.FILTER_CYCLES(FILTER_CYCLES), .RESET_VAL(STROBE_INACTIVE)) u_oe_filt (
        .clock    (clock),
        .reset    (reset),
        .strobe_i (mc_oe),
        .strobe_o (foe)
    );

    // Address and data only need plain synchronisers; the strobe filter gives them time to settle.
    logic [MC_ADD_WIDTH-1:0]  addr_s1_q;
    logic [MC_ADD_WIDTH-1:0]  addr_s2_q;
    logic [MC_DATA_WIDTH-1:0] data_s1_q;
    logic [MC_DATA_WIDTH-1:0] data_s2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_s1_q <= '0;
            addr_s2_q <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
        end else begin
            addr_s1_q <= mc_add;
            addr_s2_q <= addr_s1_q;
            data_s1_q <= mc_data_i;
            data_s2_q <= data_s1_q;
        end
    end

    state_e                   state_q;
    state_e                   state_d;
    rd_phase_e                rd_phase_q;
    rd_phase_e                rd_phase_d;
    logic [MC_ADD_WIDTH-1:0]  reg_addr_q;
    logic [MC_ADD_WIDTH-1:0]  reg_addr_d;
    logic [MC_DATA_WIDTH-1:0] reg_wdata_q;
    logic [MC_DATA_WIDTH-1:0] reg_wdata_d;
    logic                     reg_wr_q;
    logic                     reg_wr_d;
    logic                     reg_rd_q;
    logic                     reg_rd_d;
    logic                     bus_err_q;
    logic                     bus_err_d;
    logic [MC_DATA_WIDTH-1:0] data_o_q;
    logic [MC_DATA_WIDTH-1:0] data_o_d;
    logic                     data_oe_q;
    logic                     data_oe_d;

    logic ce_act;
    logic we_act;
    logic oe_act;

    assign ce_act = is_active(fce);
    assign we_act = is_active(fwe);
    assign oe_act = is_active(foe);

    // Access sequencing; pulses default low so each access yields at most one strobe.
    always_comb begin
        state_d     = state_q;
        rd_phase_d  = rd_phase_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        bus_err_d   = 1'b0;
        data_o_d    = data_o_q;
        data_oe_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ce_act) begin
                    if (we_act && oe_act) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_WAIT_IDLE;
                    end else if (we_act) begin
                        reg_addr_d  = addr_s2_q;
                        reg_wdata_d = data_s2_q;
                        state_d     = ST_WRITE;
                    end else if (oe_act) begin
                        reg_rd_d   = 1'b1;
                        reg_addr_d = addr_s2_q;
                        rd_phase_d = RD_ISSUE;
                        state_d    = ST_READ;
                    end
                end
            end

            // Commit uses the values captured one cycle before the write-enable release.
            ST_WRITE: begin
                if (oe_act) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_WAIT_IDLE;
                end else if (!ce_act) begin
                    state_d = ST_IDLE;
                end else if (!we_act) begin
                    reg_wr_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    reg_addr_d  = addr_s2_q;
                    reg_wdata_d = data_s2_q;
                end
            end

            // Register data arrives the cycle after the read strobe and is held until release.
            ST_READ: begin
                if (we_act) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_WAIT_IDLE;
                end else if (!oe_act || !ce_act) begin
                    state_d = ST_IDLE;
                end else begin
                    case (rd_phase_q)
                        RD_ISSUE: begin
                            rd_phase_d = RD_CAPTURE;
                        end
                        RD_CAPTURE: begin
                            data_o_d   = reg_rdata;
                            data_oe_d  = 1'b1;
                            rd_phase_d = RD_HOLD;
                        end
                        default: begin
                            data_oe_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_WAIT_IDLE: begin
                if (!we_act && !oe_act) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_phase_q  <= RD_ISSUE;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            data_o_q    <= '0;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_phase_q  <= rd_phase_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            bus_err_q   <= bus_err_d;
            data_o_q    <= data_o_d;
            data_oe_q   <= data_oe_d;
        end
    end

    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign reg_wr     = reg_wr_q;
    assign reg_rd     = reg_rd_q;
    assign bus_err    = bus_err_q;
    assign mc_data_o  = data_o_q;
    assign mc_data_oe = data_oe_q;

endmodule

// File: tb/tb_mc_bus_bridge.sv
// Directed bench for mc_bus_bridge: write, read, glitch, contention, CE abort and reset cases.
module tb_mc_bus_bridge;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 6;
    localparam int unsigned FC = 2;

    logic          clock;
    logic          reset;
    logic          mc_ce;
    logic          mc_we;
    logic          mc_oe;
    logic [AW-1:0] mc_add;
    logic [DW-1:0] mc_data_i;
    logic [DW-1:0] mc_data_o;
    logic          mc_data_oe;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          reg_wr;
    logic          reg_rd;
    logic [DW-1:0] reg_rdata;
    logic          bus_err;

    int errors = 0;
    int checks = 0;

    int            wr_count   = 0;
    int            rd_count   = 0;
    int            err_count  = 0;
    int            oe_cycles  = 0;
    logic [AW-1:0] wr_addr    = '0;
    logic [DW-1:0] wr_data    = '0;
    logic [AW-1:0] rd_addr    = '0;
    logic [DW-1:0] oe_data    = '0;

    mc_bus_bridge #(
        .MC_DATA_WIDTH (DW),
        .MC_ADD_WIDTH  (AW),
        .FILTER_CYCLES (FC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mc_ce      (mc_ce),
        .mc_we      (mc_we),
        .mc_oe      (mc_oe),
        .mc_add     (mc_add),
        .mc_data_i  (mc_data_i),
        .mc_data_o  (mc_data_o),
        .mc_data_oe (mc_data_oe),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_rdata  (reg_rdata),
        .bus_err    (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file model: read data valid the cycle after reg_rd.
    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        if (a == AW'(0)) return 16'h00AA;
        return 16'h5A00 | DW'(a);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) reg_rdata <= '0;
        else if (reg_rd) reg_rdata <= rd_model(reg_addr);
    end

    always @(negedge clock) begin
        if (reg_wr === 1'b1) begin
            wr_count = wr_count + 1;
            wr_addr  = reg_addr;
            wr_data  = reg_wdata;
        end
        if (reg_rd === 1'b1) begin
            rd_count = rd_count + 1;
            rd_addr  = reg_addr;
        end
        if (bus_err === 1'b1) err_count = err_count + 1;
        if (mc_data_oe === 1'b1) begin
            oe_cycles = oe_cycles + 1;
            oe_data   = mc_data_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1;
        mc_add = '0; mc_data_i = '0;
        tick(2);
        checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL reset_reg_wr got=%b exp=0", reg_wr); end
        checks++; if (reg_rd !== 1'b0) begin errors++; $display("FAIL reset_reg_rd got=%b exp=0", reg_rd); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
        checks++; if (mc_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe got=%b exp=0", mc_data_oe); end
        checks++; if (mc_data_o !== 16'h0000) begin errors++; $display("FAIL reset_data_o got=%h exp=0000", mc_data_o); end
        checks++; if (reg_addr !== 6'h00) begin errors++; $display("FAIL reset_reg_addr got=%h exp=00", reg_addr); end
        checks++; if (reg_wdata !== 16'h0000) begin errors++; $display("FAIL reset_reg_wdata got=%h exp=0000", reg_wdata); end
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_write();
        int b_wr = wr_count;
        int b_rd = rd_count;
        int lat  = 0;
        mc_add = 6'h19; mc_data_i = 16'h0001; mc_ce = 1'b0;
        tick(2);
        mc_we = 1'b0;
        tick(6);
        mc_we = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (reg_wr === 1'b1 && lat == 0) lat = i;
        end
        checks++; if (lat != 5) begin errors++; $display("FAIL write_latency got=%0d exp=5", lat); end
        checks++; if (wr_count - b_wr != 1) begin errors++; $display("FAIL write_count got=%0d exp=1", wr_count - b_wr); end
        checks++; if (wr_addr !== 6'h19) begin errors++; $display("FAIL write_addr got=%h exp=19", wr_addr); end
        checks++; if (wr_data !== 16'h0001) begin errors++; $display("FAIL write_data got=%h exp=0001", wr_data); end
        checks++; if (rd_count - b_rd != 0) begin errors++; $display("FAIL write_no_rd got=%0d exp=0", rd_count - b_rd); end
        mc_ce = 1'b1;
        tick(6);
    endtask

    task automatic test_read();
        int b_wr = wr_count;
        int b_rd = rd_count;
        int b_oe = oe_cycles;
        mc_add = 6'h00; mc_ce = 1'b0;
        tick(2);
        mc_oe = 1'b0;
        tick(6);
        mc_oe = 1'b1;
        tick(12);
        checks++; if (rd_count - b_rd != 1) begin errors++; $display("FAIL read_count got=%0d exp=1", rd_count - b_rd); end
        checks++; if (rd_addr !== 6'h00) begin errors++; $display("FAIL read_addr got=%h exp=00", rd_addr); end
        checks++; if (oe_cycles - b_oe != 4) begin errors++; $display("FAIL read_oe_cycles got=%0d exp=4", oe_cycles - b_oe); end
        checks++; if (oe_data !== 16'h00AA) begin errors++; $display("FAIL read_data got=%h exp=00aa", oe_data); end
        checks++; if (mc_data_oe !== 1'b0) begin errors++; $display("FAIL read_oe_release got=%b exp=0", mc_data_oe); end
        checks++; if (wr_count - b_wr != 0) begin errors++; $display("FAIL read_no_wr got=%0d exp=0", wr_count - b_wr); end
        mc_ce = 1'b1;
        tick(6);
    endtask

    task automatic test_glitch();
        int b_wr  = wr_count;
        int b_err = err_count;
        mc_add = 6'h05; mc_data_i = 16'h1234; mc_ce = 1'b0;
        tick(2);
        mc_we = 1'b0;
        tick(1);
        mc_we = 1'b1;
        tick(10);
        checks++; if (wr_count - b_wr != 0) begin errors++; $display("FAIL glitch_short_wr got=%0d exp=0", wr_count - b_wr); end
        checks++; if (err_count - b_err != 0) begin errors++; $display("FAIL glitch_short_err got=%0d exp=0", err_count - b_err); end
        mc_we = 1'b0;
        tick(4);
        mc_we = 1'b1;
        tick(12);
        checks++; if (wr_count - b_wr != 1) begin errors++; $display("FAIL glitch_long_wr got=%0d exp=1", wr_count - b_wr); end
        checks++; if (wr_addr !== 6'h05 || wr_data !== 16'h1234) begin
            errors++; $display("FAIL glitch_long_payload got=%h/%h exp=05/1234", wr_addr, wr_data);
        end
        mc_ce = 1'b1;
        tick(6);
    endtask

    task automatic test_contention();
        int b_wr  = wr_count;
        int b_rd  = rd_count;
        int b_err = err_count;
        mc_add = 6'h11; mc_data_i = 16'hFFFF; mc_ce = 1'b0;
        tick(2);
        mc_we = 1'b0; mc_oe = 1'b0;
        tick(16);
        checks++; if (err_count - b_err != 1) begin errors++; $display("FAIL contention_err got=%0d exp=1", err_count - b_err); end
        checks++; if (wr_count - b_wr != 0 || rd_count - b_rd != 0) begin
            errors++; $display("FAIL contention_strobes got=wr%0d/rd%0d exp=0/0", wr_count - b_wr, rd_count - b_rd);
        end
        mc_we = 1'b1; mc_oe = 1'b1;
        tick(8);
        mc_add = 6'h1a; mc_data_i = 16'h0003;
        mc_we = 1'b0;
        tick(6);
        mc_we = 1'b1;
        tick(12);
        checks++; if (wr_count - b_wr != 1) begin errors++; $display("FAIL contention_recover_wr got=%0d exp=1", wr_count - b_wr); end
        checks++; if (wr_addr !== 6'h1a || wr_data !== 16'h0003) begin
            errors++; $display("FAIL contention_recover_payload got=%h/%h exp=1a/0003", wr_addr, wr_data);
        end
        checks++; if (err_count - b_err != 1) begin errors++; $display("FAIL contention_err_total got=%0d exp=1", err_count - b_err); end
        mc_ce = 1'b1;
        tick(6);
    endtask

    task automatic test_ce_abort();
        int b_wr  = wr_count;
        int b_err = err_count;
        mc_add = 6'h07; mc_data_i = 16'h0707; mc_ce = 1'b0;
        tick(2);
        mc_we = 1'b0;
        tick(6);
        mc_ce = 1'b1;
        tick(2);
        mc_we = 1'b1;
        tick(12);
        checks++; if (wr_count - b_wr != 0) begin errors++; $display("FAIL ce_abort_wr got=%0d exp=0", wr_count - b_wr); end
        checks++; if (err_count - b_err != 0) begin errors++; $display("FAIL ce_abort_err got=%0d exp=0", err_count - b_err); end
    endtask

    task automatic test_reset_mid_write();
        int b_wr;
        mc_add = 6'h2b; mc_data_i = 16'hBEEF; mc_ce = 1'b0;
        tick(2);
        mc_we = 1'b0;
        tick(6);
        checks++; if (reg_addr !== 6'h2b) begin errors++; $display("FAIL midrst_pre_addr got=%h exp=2b", reg_addr); end
        reset = 1'b1;
        #1;
        checks++; if (reg_addr !== 6'h00 || reg_wdata !== 16'h0000) begin
            errors++; $display("FAIL midrst_async_clear got=%h/%h exp=00/0000", reg_addr, reg_wdata);
        end
        tick(2);
        b_wr = wr_count;
        reset = 1'b0;
        tick(8);
        mc_we = 1'b1;
        tick(12);
        checks++; if (wr_count - b_wr != 1) begin errors++; $display("FAIL midrst_held_wr got=%0d exp=1", wr_count - b_wr); end
        checks++; if (wr_addr !== 6'h2b || wr_data !== 16'hBEEF) begin
            errors++; $display("FAIL midrst_held_payload got=%h/%h exp=2b/beef", wr_addr, wr_data);
        end
        mc_ce = 1'b1;
        tick(6);
        mc_ce = 1'b0;
        tick(2);
        mc_we = 1'b0;
        tick(6);
        reset = 1'b1;
        mc_we = 1'b1;
        tick(2);
        b_wr = wr_count;
        reset = 1'b0;
        tick(12);
        checks++; if (wr_count - b_wr != 0) begin errors++; $display("FAIL midrst_released_wr got=%0d exp=0", wr_count - b_wr); end
        mc_ce = 1'b1;
        tick(6);
    endtask

    initial begin
        reset = 1'b1;
        mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1;
        mc_add = '0; mc_data_i = '0;
        test_reset();
        test_write();
        test_read();
        test_glitch();
        test_contention();
        test_ce_abort();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
